pcr_arbiter: RTL and testbench
==============================

Name: pcr_arbiter

Overview:
- Shares the single-outstanding performance-counter-register (PCR) bus among NUM_REQ requesters. Requester 0 is the CSR unit's PCR port; requester 1 is the debug ring.
- Sits between the CSR/debug logic and the external PCR module.
- Arbitrates round-robin, holds one transaction in flight, matches the response by core id, and returns an error response on timeout.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- TIMEOUT_CYCLES, 1024, cycles to wait for a response after PCR accept. 0 disables the timeout.
- TO_W, 11, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- core_id_i  in  64  id of this tile; sampled at request accept.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_addr_i  in  NUM_REQ x 12  PCR address per requester.
- req_data_i  in  NUM_REQ x 64  write data per requester.
- req_we_i  in  NUM_REQ x 3  command per requester.
- resp_valid_o  out  NUM_REQ  one-cycle response strobe to the owning requester.
- resp_data_o  out  64  response data, shared by all requesters.
- resp_err_o  out  1  response was a timeout; qualified by resp_valid_o.
- pcr_req_valid_o  out  1  PCR request valid.
- pcr_req_ready_i  in  1  PCR request ready.
- pcr_req_addr_o  out  12  latched address.
- pcr_req_data_o  out  64  latched data.
- pcr_req_we_o  out  3  latched command.
- pcr_req_core_id_o  out  64  latched core id.
- pcr_resp_valid_i  in  1  PCR response valid.
- pcr_resp_data_i  in  64  PCR response data.
- pcr_resp_core_id_i  in  64  core id tag of the response.
- busy_o  out  1  a transaction is in flight (state != IDLE).

Behaviour:
- Reset: state=IDLE, rr_ptr=0, owner=0, timeout counter=0. All outputs are 0, including the latched payload.
- States: IDLE, REQ, WAIT.
- IDLE:
  - Grant = first set req_valid_i scanning from rr_ptr upward, modulo NUM_REQ.
  - req_ready_o[grant]=1 combinationally in the same cycle. req_ready_o=0 in all other states.
  - On grant, latch addr/data/we, core_id_i and owner=grant, then go to REQ.
- REQ:
  - pcr_req_valid_o=1 with payload stable.
  - On pcr_req_valid_o & pcr_req_ready_i, go to WAIT and clear the counter.
  - pcr_resp_valid_i is ignored in REQ.
- WAIT:
  - Counter increments every cycle.
  - A match is pcr_resp_valid_i=1 and pcr_resp_core_id_i == latched core id. On match, go to IDLE and register resp_valid_o[owner]=1, resp_data_o=pcr_resp_data_i, resp_err_o=0 for exactly the next cycle.
  - Non-matching responses are ignored.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without a match, go to IDLE and register resp_valid_o[owner]=1, resp_data_o=0, resp_err_o=1.
  - A match and expiry in the same cycle: the match wins, err=0.
- rr_ptr update: rr_ptr=(owner+1) mod NUM_REQ when leaving WAIT. Wrap from NUM_REQ-1 goes to 0.
- Latency:
  - Accept at cycle t gives pcr_req_valid_o at t+1.
  - A match at cycle m gives resp_valid_o at m+1. A new grant is possible at m+1, so the response strobe and the next accept may coincide.
- resp_valid_o, resp_data_o and resp_err_o are 0 in every cycle without a strobe.
- Requesters may drop req_valid_i before acceptance with no side effect. Payload is sampled only on accept.
- Reset asserted mid-transaction: immediate return to the reset state. The in-flight response is discarded; no strobe is issued.

Test Plan:
- Single request: req_valid_i=2'b01, addr=12'hB03, we=3'd1, core_id_i=5. Expect req_ready_o=01 the same cycle, then pcr_req_valid_o with addr B03 and core_id 5. Hold pcr_req_ready_i=0 for 3 cycles, then 1. Response data=64'hDEAD with core_id 5 arrives 4 cycles later. Expect resp_valid_o=01, data=DEAD, err=0 one cycle after the match.
- Contention: both requesters valid continuously. Grants alternate 0,1,0,1 across four transactions; rr_ptr wraps 1->0.
- Core-id filter: in WAIT, a response with core_id 7 is ignored (busy_o stays 1). A following response with core_id 5 completes the transaction.
- Timeout: TIMEOUT_CYCLES=8, no response after accept. Exactly 8 cycles after the accept handshake: resp_valid_o[owner]=1, err=1, data=0; state returns to IDLE.
- Tie case and response in REQ: a match arriving on the expiry cycle gives err=0 with the real data. A response arriving during REQ is ignored and the transaction still waits for a response in WAIT.
- Reset mid-operation: assert rst_i during WAIT. Expect all outputs 0 asynchronously and no resp_valid_o after release. The next request is granted from rr_ptr=0.

Source files
------------

// File: rtl/pcr_arbiter.sv
// pcr_arbiter: shares the single-outstanding PCR bus among NUM_REQ requesters.
// Requester 0 is the CSR unit's PCR port and requester 1 is the debug ring.
// One transaction is in flight at a time. Requesters are granted round-robin.
// The response is matched by core id. A missing response ends with an error
// strobe once the timeout expires.
module pcr_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [63:0]           core_id_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*12-1:0] req_addr_i,
  input  logic [NUM_REQ*64-1:0] req_data_i,
  input  logic [NUM_REQ*3-1:0]  req_we_i,
  output logic [NUM_REQ-1:0]    resp_valid_o,
  output logic [63:0]           resp_data_o,
  output logic                  resp_err_o,
  output logic                  pcr_req_valid_o,
  input  logic                  pcr_req_ready_i,
  output logic [11:0]           pcr_req_addr_o,
  output logic [63:0]           pcr_req_data_o,
  output logic [2:0]            pcr_req_we_o,
  output logic [63:0]           pcr_req_core_id_o,
  input  logic                  pcr_resp_valid_i,
  input  logic [63:0]           pcr_resp_data_i,
  input  logic [63:0]           pcr_resp_core_id_i,
  output logic                  busy_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int SUM_W = PTR_W + 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  // Counter value seen in the last WAIT cycle before the transaction expires.
  localparam logic [TO_W-1:0]  TO_LAST  = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1)
                                                                : {TO_W{1'b0}};
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;
  logic [11:0]        addr_q, addr_d;
  logic [63:0]        data_q, data_d;
  logic [2:0]         we_q, we_d;
  logic [63:0]        core_id_q, core_id_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [63:0]        resp_data_q, resp_data_d;
  logic               resp_err_q, resp_err_d;

  logic               grant_found_s;
  logic [PTR_W-1:0]   grant_idx_s;
  logic [11:0]        sel_addr_s;
  logic [63:0]        sel_data_s;
  logic [2:0]         sel_we_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic               match_s;
  logic               expire_s;

  // One-hot vector with bit idx set.
  function automatic logic [NUM_REQ-1:0] onehot_f(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      vec[i] = (idx == PTR_W'(i));
    end
    return vec;
  endfunction

  // Requester index after idx, wrapping from the last requester back to 0.
  function automatic logic [PTR_W-1:0] next_idx_f(input logic [PTR_W-1:0] idx);
    logic [PTR_W-1:0] nxt;
    if (idx == LAST_IDX) begin
      nxt = {PTR_W{1'b0}};
    end else begin
      nxt = idx + PTR_W'(1);
    end
    return nxt;
  endfunction

  // Round-robin search: first valid requester at or after rr_ptr, modulo NUM_REQ.
  always_comb begin
    logic [SUM_W-1:0] raw_v;
    logic [SUM_W-1:0] pos_v;
    logic             take_v;
    raw_v         = {SUM_W{1'b0}};
    pos_v         = {SUM_W{1'b0}};
    take_v        = 1'b0;
    grant_found_s = 1'b0;
    grant_idx_s   = {PTR_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      raw_v         = {1'b0, rr_ptr_q} + SUM_W'(k);
      pos_v         = (raw_v >= SUM_W'(NUM_REQ)) ? (raw_v - SUM_W'(NUM_REQ)) : raw_v;
      take_v        = !grant_found_s && req_valid_i[pos_v[PTR_W-1:0]];
      grant_idx_s   = take_v ? pos_v[PTR_W-1:0] : grant_idx_s;
      grant_found_s = grant_found_s | take_v;
    end
  end

  // Payload of the granted requester, selected as an AND-OR mux.
  always_comb begin
    sel_addr_s = 12'd0;
    sel_data_s = 64'd0;
    sel_we_s   = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s = sel_addr_s | (req_addr_i[i*12 +: 12] & {12{grant_idx_s == PTR_W'(i)}});
      sel_data_s = sel_data_s | (req_data_i[i*64 +: 64] & {64{grant_idx_s == PTR_W'(i)}});
      sel_we_s   = sel_we_s   | (req_we_i[i*3 +: 3]     & {3{grant_idx_s == PTR_W'(i)}});
    end
  end

  assign match_s  = pcr_resp_valid_i && (pcr_resp_core_id_i == core_id_q);
  assign expire_s = TO_EN && (cnt_q == TO_LAST);

  // Next-state logic: accept in IDLE, hand off in REQ, match or time out in WAIT.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = we_q;
    core_id_d    = core_id_q;
    resp_valid_d = {NUM_REQ{1'b0}};
    resp_data_d  = 64'd0;
    resp_err_d   = 1'b0;
    req_ready_s  = {NUM_REQ{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          req_ready_s = onehot_f(grant_idx_s);
          addr_d      = sel_addr_s;
          data_d      = sel_data_s;
          we_d        = sel_we_s;
          core_id_d   = core_id_i;
          owner_d     = grant_idx_s;
          state_d     = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Responses are not looked at until the request has been handed off.
        if (pcr_req_ready_i) begin
          cnt_d   = {TO_W{1'b0}};
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        // A match on the expiry cycle still returns the real data.
        if (match_s) begin
          resp_valid_d = onehot_f(owner_q);
          resp_data_d  = pcr_resp_data_i;
          rr_ptr_d     = next_idx_f(owner_q);
          state_d      = ST_IDLE;
        end else if (expire_s) begin
          resp_valid_d = onehot_f(owner_q);
          resp_err_d   = 1'b1;
          rr_ptr_d     = next_idx_f(owner_q);
          state_d      = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + TO_W'(1);
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, arbitration pointer, counter, latched payload and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= {PTR_W{1'b0}};
      owner_q      <= {PTR_W{1'b0}};
      cnt_q        <= {TO_W{1'b0}};
      addr_q       <= 12'd0;
      data_q       <= 64'd0;
      we_q         <= 3'd0;
      core_id_q    <= 64'd0;
      resp_valid_q <= {NUM_REQ{1'b0}};
      resp_data_q  <= 64'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      core_id_q    <= core_id_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // The grant is combinational, so it is masked while reset is held so that
  // every output reads zero during reset.
  assign req_ready_o       = rst_i ? {NUM_REQ{1'b0}} : req_ready_s;
  assign pcr_req_valid_o   = (state_q == ST_REQ);
  assign pcr_req_addr_o    = addr_q;
  assign pcr_req_data_o    = data_q;
  assign pcr_req_we_o      = we_q;
  assign pcr_req_core_id_o = core_id_q;
  assign resp_valid_o      = resp_valid_q;
  assign resp_data_o       = resp_data_q;
  assign resp_err_o        = resp_err_q;
  assign busy_o            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pcr_arbiter.sv
// Testbench for pcr_arbiter with two requesters and an 8-cycle timeout.
// It runs a directed vector table, hand-written corner-case sequences, and
// random traffic checked against a transaction-level reference model.
module tb_pcr_arbiter;
  localparam int N = 2;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  core_id;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [23:0]  req_addr;
  logic [127:0] req_data;
  logic [5:0]   req_we;
  logic [1:0]   resp_valid;
  logic [63:0]  resp_data;
  logic         resp_err;
  logic         pcr_valid;
  logic         pready;
  logic [11:0]  pcr_addr;
  logic [63:0]  pcr_data;
  logic [2:0]   pcr_we;
  logic [63:0]  pcr_core;
  logic         rspv;
  logic [63:0]  rdata;
  logic [63:0]  rcid;
  logic         busy;

  always #5 clk = ~clk;

  pcr_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T), .TO_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .core_id_i(core_id),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_we_i(req_we),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_err_o(resp_err),
    .pcr_req_valid_o(pcr_valid), .pcr_req_ready_i(pready),
    .pcr_req_addr_o(pcr_addr), .pcr_req_data_o(pcr_data), .pcr_req_we_o(pcr_we),
    .pcr_req_core_id_o(pcr_core), .pcr_resp_valid_i(rspv),
    .pcr_resp_data_i(rdata), .pcr_resp_core_id_i(rcid), .busy_o(busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          m_busy, m_sent, m_age, m_rr, m_owner;
  logic [11:0] m_addr;
  logic [63:0] m_data, m_core, m_rdata;
  logic [2:0]  m_we;
  logic [1:0]  m_rv;
  logic        m_rerr;
  logic [1:0]  obs_ready, obs_rv;
  logic        obs_pv, obs_busy, obs_err;
  logic [63:0] obs_rdata;

  task automatic model_reset();
    m_busy = 0; m_sent = 0; m_age = 0; m_rr = 0; m_owner = 0;
    m_addr = 12'd0; m_data = 64'd0; m_core = 64'd0; m_we = 3'd0;
    m_rv = 2'b00; m_rdata = 64'd0; m_rerr = 1'b0;
  endtask

  function automatic int pick(input logic [1:0] v, input int rr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_idle();
    req_valid = 2'b00; req_addr = 24'd0; req_data = 128'd0; req_we = 6'd0;
    core_id = 64'd0; pready = 1'b0; rspv = 1'b0; rcid = 64'd0; rdata = 64'd0;
  endtask

  // Check this cycle's outputs against the model, advance the model, then clock.
  task automatic run_cycle();
    int         g;
    logic [1:0] exp_rdy, n_rv;
    logic [63:0] n_rdata;
    logic       n_err_b;
    #1;
    g       = (m_busy != 0) ? -1 : pick(req_valid, m_rr);
    exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
    obs_ready = req_ready; obs_pv = pcr_valid; obs_busy = busy;
    obs_rv = resp_valid; obs_rdata = resp_data; obs_err = resp_err;
    chk("req_ready", req_ready, exp_rdy);
    chk("pcr_valid", pcr_valid, (m_busy != 0 && m_sent == 0) ? 1'b1 : 1'b0);
    chk("pcr_addr", pcr_addr, m_addr);
    chk("pcr_data", pcr_data, m_data);
    chk("pcr_we", pcr_we, m_we);
    chk("pcr_core", pcr_core, m_core);
    chk("busy", busy, (m_busy != 0) ? 1'b1 : 1'b0);
    chk("resp_valid", resp_valid, m_rv);
    chk("resp_data", resp_data, m_rdata);
    chk("resp_err", resp_err, m_rerr);
    n_rv = 2'b00; n_rdata = 64'd0; n_err_b = 1'b0;
    if (m_busy == 0) begin
      if (g >= 0) begin
        m_addr = req_addr[g*12 +: 12]; m_data = req_data[g*64 +: 64];
        m_we = req_we[g*3 +: 3]; m_core = core_id; m_owner = g;
        m_busy = 1; m_sent = 0;
      end
    end else if (m_sent == 0) begin
      if (pready) begin m_sent = 1; m_age = 0; end
    end else begin
      if (rspv && rcid == m_core) begin
        n_rv = 2'(1 << m_owner); n_rdata = rdata; m_busy = 0; m_rr = (m_owner + 1) % N;
      end else if (m_age == T - 1) begin
        n_rv = 2'(1 << m_owner); n_err_b = 1'b1; m_busy = 0; m_rr = (m_owner + 1) % N;
      end else begin
        m_age++;
      end
    end
    m_rv = n_rv; m_rdata = n_rdata; m_rerr = n_err_b;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  rv;   logic [11:0] addr; logic [2:0] we;  logic [63:0] cid;
    logic        prdy; logic rspv; logic [63:0] rcid; logic [63:0] rdata;
    logic [1:0]  e_rdy; logic e_pv; logic [11:0] e_paddr; logic [63:0] e_pcid;
    logic        e_busy; logic [1:0] e_rv; logic [63:0] e_rdata; logic e_err;
  } vec_t;

  vec_t tbl[17];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [1:0] grants[$];
    int         first_k;
    logic [1:0] to_rv;
    logic [63:0] to_data;
    logic       to_err;

    // Single request, then core-id filter, then round-robin wrap back to 0.
    tbl[0]  = '{2'b01, 12'hB03, 3'd1, 64'd5, 1'b0, 1'b0, 64'd0, 64'd0,      2'b01, 1'b0, 12'h000, 64'd0, 1'b0, 2'b00, 64'd0,      1'b0};
    tbl[1]  = '{2'b00, 12'h000, 3'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0,      2'b00, 1'b1, 12'hB03, 64'd5, 1'b1, 2'b00, 64'd0,      1'b0};
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = '{2'b00, 12'h000, 3'd0, 64'd0, 1'b1, 1'b0, 64'd0, 64'd0,      2'b00, 1'b1, 12'hB03, 64'd5, 1'b1, 2'b00, 64'd0,      1'b0};
    tbl[5]  = '{2'b00, 12'h000, 3'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0,      2'b00, 1'b0, 12'hB03, 64'd5, 1'b1, 2'b00, 64'd0,      1'b0};
    tbl[6]  = tbl[5];
    tbl[7]  = tbl[5];
    tbl[8]  = '{2'b00, 12'h000, 3'd0, 64'd0, 1'b0, 1'b1, 64'd5, 64'hDEAD,   2'b00, 1'b0, 12'hB03, 64'd5, 1'b1, 2'b00, 64'd0,      1'b0};
    tbl[9]  = '{2'b00, 12'h000, 3'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0,      2'b00, 1'b0, 12'hB03, 64'd5, 1'b0, 2'b01, 64'hDEAD,   1'b0};
    tbl[10] = '{2'b11, 12'h0A1, 3'd2, 64'd5, 1'b0, 1'b0, 64'd0, 64'd0,      2'b10, 1'b0, 12'hB03, 64'd5, 1'b0, 2'b00, 64'd0,      1'b0};
    tbl[11] = '{2'b00, 12'h000, 3'd0, 64'd0, 1'b1, 1'b0, 64'd0, 64'd0,      2'b00, 1'b1, 12'h0A1, 64'd5, 1'b1, 2'b00, 64'd0,      1'b0};
    tbl[12] = '{2'b00, 12'h000, 3'd0, 64'd0, 1'b0, 1'b1, 64'd7, 64'hBEEF,   2'b00, 1'b0, 12'h0A1, 64'd5, 1'b1, 2'b00, 64'd0,      1'b0};
    tbl[13] = '{2'b00, 12'h000, 3'd0, 64'd0, 1'b0, 1'b1, 64'd5, 64'h55,     2'b00, 1'b0, 12'h0A1, 64'd5, 1'b1, 2'b00, 64'd0,      1'b0};
    tbl[14] = '{2'b00, 12'h000, 3'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0,      2'b00, 1'b0, 12'h0A1, 64'd5, 1'b0, 2'b10, 64'h55,     1'b0};
    tbl[15] = '{2'b11, 12'h777, 3'd3, 64'd9, 1'b0, 1'b0, 64'd0, 64'd0,      2'b01, 1'b0, 12'h0A1, 64'd5, 1'b0, 2'b00, 64'd0,      1'b0};
    tbl[16] = '{2'b00, 12'h000, 3'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0,      2'b00, 1'b1, 12'h777, 64'd9, 1'b1, 2'b00, 64'd0,      1'b0};

    // Reset state.
    rst = 1'b1;
    set_idle();
    @(posedge clk); @(posedge clk); #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_pcr_valid", pcr_valid, 1'b0);
    chk("reset_resp_valid", resp_valid, 2'b00);
    chk("reset_pcr_addr", pcr_addr, 12'h000);
    chk("reset_pcr_core", pcr_core, 64'd0);
    rst = 1'b0;
    model_reset();

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      req_valid = tbl[i].rv;
      req_addr  = {tbl[i].addr, tbl[i].addr};
      req_we    = {tbl[i].we, tbl[i].we};
      req_data  = {64'h1234, 64'h1234};
      core_id   = tbl[i].cid;
      pready    = tbl[i].prdy;
      rspv      = tbl[i].rspv;
      rcid      = tbl[i].rcid;
      rdata     = tbl[i].rdata;
      #1;
      chk("tbl_req_ready", req_ready, tbl[i].e_rdy);
      chk("tbl_pcr_valid", pcr_valid, tbl[i].e_pv);
      chk("tbl_pcr_addr", pcr_addr, tbl[i].e_paddr);
      chk("tbl_pcr_core", pcr_core, tbl[i].e_pcid);
      chk("tbl_busy", busy, tbl[i].e_busy);
      chk("tbl_resp_valid", resp_valid, tbl[i].e_rv);
      chk("tbl_resp_data", resp_data, tbl[i].e_rdata);
      chk("tbl_resp_err", resp_err, tbl[i].e_err);
      @(posedge clk); #1;
    end

    // Contention: both requesters always valid, grants must alternate.
    do_reset();
    for (int c = 0; c < 80 && grants.size() < 4; c++) begin
      set_idle();
      req_valid = 2'b11; req_addr = {12'h222, 12'h111};
      req_data = {64'hB0B, 64'hA0A}; req_we = {3'd2, 3'd1}; core_id = 64'd5;
      pready = 1'b1; rspv = (m_busy != 0 && m_sent != 0); rcid = 64'd5; rdata = 64'(c);
      run_cycle();
      if (obs_ready != 2'b00) grants.push_back(obs_ready);
    end
    chk("grant_count", grants.size(), 4);
    foreach (grants[i]) chk("grant_order", grants[i], (i % 2 == 0) ? 2'b01 : 2'b10);

    // Timeout: strobe lands eight clock edges after the handshake edge.
    do_reset();
    set_idle(); req_valid = 2'b01; core_id = 64'd5; req_addr = 24'h000321;
    run_cycle();
    set_idle(); pready = 1'b1;
    run_cycle();
    first_k = -1; to_rv = 2'b00; to_data = 64'd0; to_err = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      set_idle();
      run_cycle();
      if (obs_rv != 2'b00 && first_k < 0) begin
        first_k = k; to_rv = obs_rv; to_data = obs_rdata; to_err = obs_err;
      end
    end
    chk("timeout_delay", 64'(first_k), 64'd9);
    chk("timeout_rv", to_rv, 2'b01);
    chk("timeout_err", to_err, 1'b1);
    chk("timeout_data", to_data, 64'd0);

    // Response during REQ is ignored; a match on the expiry cycle wins.
    set_idle(); req_valid = 2'b10; core_id = 64'd6; req_addr = 24'h456000;
    run_cycle();
    chk("tie_grant", obs_ready, 2'b10);
    for (int k = 0; k < 2; k++) begin
      set_idle(); rspv = 1'b1; rcid = 64'd6; rdata = 64'hAAAA;
      run_cycle();
    end
    set_idle(); pready = 1'b1;
    run_cycle();
    chk("req_resp_ignored", obs_pv, 1'b1);
    for (int k = 0; k < T - 1; k++) begin
      set_idle();
      run_cycle();
    end
    set_idle(); rspv = 1'b1; rcid = 64'd6; rdata = 64'hC0FFEE;
    run_cycle();
    set_idle();
    run_cycle();
    chk("tie_rv", obs_rv, 2'b10);
    chk("tie_err", obs_err, 1'b0);
    chk("tie_data", obs_rdata, 64'hC0FFEE);

    // Reset during WAIT: requester 1 owns the bus and rr_ptr has moved to 1.
    set_idle(); req_valid = 2'b01; core_id = 64'd5;
    run_cycle();
    set_idle(); pready = 1'b1;
    run_cycle();
    set_idle(); rspv = 1'b1; rcid = 64'd5; rdata = 64'h1;
    run_cycle();
    set_idle(); req_valid = 2'b11; core_id = 64'd6;
    run_cycle();
    chk("pre_reset_grant", obs_ready, 2'b10);
    set_idle(); pready = 1'b1;
    run_cycle();
    set_idle(); run_cycle();
    set_idle(); run_cycle();
    req_valid = 2'b11; rspv = 1'b1; rcid = 64'd6; rdata = 64'h99;
    rst = 1'b1;
    #1;
    chk("async_rst_ready", req_ready, 2'b00);
    chk("async_rst_pcr_valid", pcr_valid, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_pcr_addr", pcr_addr, 12'h000);
    chk("async_rst_pcr_data", pcr_data, 64'd0);
    chk("async_rst_pcr_we", pcr_we, 3'd0);
    chk("async_rst_pcr_core", pcr_core, 64'd0);
    chk("async_rst_resp_valid", resp_valid, 2'b00);
    chk("async_rst_resp_data", resp_data, 64'd0);
    chk("async_rst_resp_err", resp_err, 1'b0);
    @(posedge clk); #1;
    set_idle();
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      set_idle(); run_cycle();
    end
    set_idle(); req_valid = 2'b11; core_id = 64'd5;
    run_cycle();
    chk("post_reset_grant", obs_ready, 2'b01);

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_addr  = 24'($urandom);
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      req_we    = 6'($urandom);
      core_id   = ($urandom_range(0, 1) != 0) ? 64'd5 : 64'd6;
      pready    = ($urandom_range(0, 2) != 0);
      rspv      = ($urandom_range(0, 3) == 0);
      rcid      = 64'($urandom_range(5, 7));
      rdata     = {$urandom, $urandom};
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
